// File: rtl/tdm_pkg.sv
// Shared constants, state type and slot helper for the TDM link.
package tdm_pkg;

  localparam int unsigned CHANNELS = 8;
  localparam int unsigned SEL_W    = 3;

  typedef enum logic {
    StHunt,
    StRun
  } tdm_state_e;

  // Modulo-CHANNELS increment of a slot index.
  function automatic logic [SEL_W-1:0] next_slot(input logic [SEL_W-1:0] s);
    logic [SEL_W-1:0] r;
    if (s == SEL_W'(CHANNELS - 1)) r = '0;
    else                           r = s + 1'b1;
    return r;
  endfunction

endpackage

// File: rtl/tdm_slot_ctr.sv
// Modulo-CHANNELS slot counter with clear, load-to-1 and increment; shared with the TX side.
module tdm_slot_ctr
  import tdm_pkg::*;
(
  input  logic             i_clk,
  input  logic             i_rst_n,
  input  logic             i_inc,
  input  logic             i_load1,
  input  logic             i_clr,
  output logic [SEL_W-1:0] o_count,
  output logic             o_wrap
);

  logic [SEL_W-1:0] r_count;
  logic [SEL_W-1:0] w_count_d;

  // Next count: clear wins over load, load wins over increment.
  always_comb begin
    w_count_d = r_count;
    if (i_clr)        w_count_d = '0;
    else if (i_load1) w_count_d = SEL_W'(1);
    else if (i_inc)   w_count_d = next_slot(r_count);
  end

  // Count register.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) r_count <= '0;
    else          r_count <= w_count_d;
  end

  assign o_count = r_count;
  assign o_wrap  = (r_count == SEL_W'(CHANNELS - 1));

endmodule

// File: rtl/tdm_demux8.sv
// Receive end of the 8-channel TDM link: locks to frame_start, assembles frames, flags resyncs.
module tdm_demux8
  import tdm_pkg::*;
(
  input  logic                i_clk,
  input  logic                i_rst_n,
  input  logic                i_in_valid,
  input  logic                i_din,
  input  logic                i_frame_start,
  output logic [SEL_W-1:0]    o_slot,
  output logic [CHANNELS-1:0] o_ch,
  output logic                o_ch_valid,
  output logic                o_locked,
  output logic                o_sync_err
);

  tdm_state_e r_state;
  tdm_state_e w_state_d;

  // Slot 7 is never stored: it goes straight into ch with the rest of the frame.
  logic [CHANNELS-2:0] r_shadow;
  logic [CHANNELS-1:0] r_ch;
  logic                r_ch_valid;
  logic                r_sync_err;

  logic [SEL_W-1:0] w_slot;
  logic             w_wrap;
  logic             w_inc;
  logic             w_load1;
  logic             w_wr;
  logic             w_done;
  logic             w_resync;
  logic [SEL_W-1:0] w_idx;

  tdm_slot_ctr u_slot_ctr (
    .i_clk   (i_clk),
    .i_rst_n (i_rst_n),
    .i_inc   (w_inc),
    .i_load1 (w_load1),
    .i_clr   (1'b0),
    .o_count (w_slot),
    .o_wrap  (w_wrap)
  );

  // Next state and per-bit controls; nothing moves on an idle cycle.
  always_comb begin
    w_state_d = r_state;
    w_inc     = 1'b0;
    w_load1   = 1'b0;
    w_wr      = 1'b0;
    w_done    = 1'b0;
    w_resync  = 1'b0;
    if (i_in_valid) begin
      unique case (r_state)
        StHunt: begin
          if (i_frame_start) begin
            w_state_d = StRun;
            w_load1   = 1'b1;
            w_wr      = 1'b1;
          end
        end
        StRun: begin
          if (i_frame_start && (w_slot != '0)) begin
            // Misplaced marker: drop the partial frame and restart at slot 0.
            w_resync = 1'b1;
            w_load1  = 1'b1;
            w_wr     = 1'b1;
          end else begin
            w_wr   = 1'b1;
            w_inc  = 1'b1;
            w_done = w_wrap;
          end
        end
        default: w_state_d = StHunt;
      endcase
    end
  end

  assign w_idx = w_load1 ? '0 : w_slot;

  // State register.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) r_state <= StHunt;
    else          r_state <= w_state_d;
  end

  // Shadow capture of slots 0..6.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n)              r_shadow        <= '0;
    else if (w_wr && !w_done)  r_shadow[w_idx] <= i_din;
  end

  // Output registers: frame word plus one-cycle valid and error pulses.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_ch       <= '0;
      r_ch_valid <= 1'b0;
      r_sync_err <= 1'b0;
    end else begin
      r_ch_valid <= w_done;
      r_sync_err <= w_resync;
      if (w_done) r_ch <= {i_din, r_shadow};
    end
  end

  assign o_slot     = w_slot;
  assign o_ch       = r_ch;
  assign o_ch_valid = r_ch_valid;
  assign o_sync_err = r_sync_err;
  assign o_locked   = (r_state == StRun);

endmodule

// File: tb/tb_tdm_demux8.sv
// Self-checking bench for tdm_demux8 against a queue-based frame model.
module tb_tdm_demux8;

  logic       clk;
  logic       rst_n;
  logic       in_valid;
  logic       din;
  logic       frame_start;
  logic [2:0] slot;
  logic [7:0] ch;
  logic       ch_valid;
  logic       locked;
  logic       sync_err;

  int n_checks = 0;
  int n_fail   = 0;

  // Reference model: bits of the current frame in arrival order.
  bit       m_run;
  bit       m_q[$];
  logic [7:0] m_ch;
  bit       m_cv;
  bit       m_se;

  tdm_demux8 dut (
    .i_clk         (clk),
    .i_rst_n       (rst_n),
    .i_in_valid    (in_valid),
    .i_din         (din),
    .i_frame_start (frame_start),
    .o_slot        (slot),
    .o_ch          (ch),
    .o_ch_valid    (ch_valid),
    .o_locked      (locked),
    .o_sync_err    (sync_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic model_reset();
    m_run = 1'b0;
    m_q.delete();
    m_ch  = 8'h00;
    m_cv  = 1'b0;
    m_se  = 1'b0;
  endtask

  task automatic model_edge(input bit v, input bit d, input bit fs);
    m_cv = 1'b0;
    m_se = 1'b0;
    if (v) begin
      if (!m_run) begin
        if (fs) begin
          m_run = 1'b1;
          m_q   = {d};
        end
      end else if (fs && m_q.size() != 0) begin
        m_se = 1'b1;
        m_q  = {d};
      end else begin
        m_q.push_back(d);
        if (m_q.size() == 8) begin
          m_ch = 8'h00;
          for (int i = 0; i < 8; i++) if (m_q[i]) m_ch = m_ch + (8'd1 << i);
          m_cv = 1'b1;
          m_q.delete();
        end
      end
    end
  endtask

  task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    n_checks++;
    assert (obs === exp)
    else begin
      n_fail++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic check_all(input string tag);
    chk({tag, ".slot"},     {5'b0, slot},       8'(m_q.size()));
    chk({tag, ".ch"},       ch,                 m_ch);
    chk({tag, ".ch_valid"}, {7'b0, ch_valid},   {7'b0, m_cv});
    chk({tag, ".locked"},   {7'b0, locked},     {7'b0, m_run});
    chk({tag, ".sync_err"}, {7'b0, sync_err},   {7'b0, m_se});
  endtask

  // One clock: drive at negedge, model at posedge, compare at the next negedge.
  task automatic step(input bit v, input bit d, input bit fs, input string tag);
    in_valid    = v;
    din         = d;
    frame_start = fs;
    @(posedge clk);
    model_edge(v, d, fs);
    @(negedge clk);
    check_all(tag);
  endtask

  task automatic send_frame(input logic [7:0] w, input bit first_fs, input string tag);
    logic [7:0] wv;
    wv = w;
    for (int i = 0; i < 8; i++) step(1'b1, wv[i], (i == 0) && first_fs, tag);
  endtask

  // Assert reset between edges and confirm outputs clear immediately.
  task automatic async_reset(input string tag);
    #2 rst_n = 1'b0;
    #1;
    model_reset();
    check_all(tag);
    in_valid    = 1'b0;
    frame_start = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  initial begin
    int pulses[$];
    int cyc;
    logic [7:0] x;
    logic [7:0] ch_before;

    rst_n = 1'b0; in_valid = 1'b0; din = 1'b0; frame_start = 1'b0;
    model_reset();
    @(negedge clk);
    @(negedge clk);
    check_all("reset");
    rst_n = 1'b1;

    // Some traffic, then reset mid-stream and decode 8'h4D.
    step(1'b1, 1'b1, 1'b1, "pre");
    step(1'b1, 1'b0, 1'b0, "pre");
    step(1'b1, 1'b1, 1'b0, "pre");
    async_reset("midrst");
    send_frame(8'h4D, 1'b1, "f4d");
    chk("f4d.const_ch", ch, 8'h4D);
    chk("f4d.const_valid", {7'b0, ch_valid}, 8'h01);
    chk("f4d.const_locked", {7'b0, locked}, 8'h01);
    step(1'b0, 1'b0, 1'b0, "f4d.after");
    chk("f4d.single_pulse", {7'b0, ch_valid}, 8'h00);

    // Data before any marker is ignored.
    async_reset("rst2");
    for (int i = 0; i < 5; i++) step(1'b1, 1'b1, 1'b0, "hunt");
    chk("hunt.slot0", {5'b0, slot}, 8'h00);
    chk("hunt.unlocked", {7'b0, locked}, 8'h00);
    send_frame(8'h96, 1'b1, "hunt.f96");
    chk("hunt.const_ch", ch, 8'h96);

    // Loopback: din comes from x selected by the receiver's own slot.
    x = 8'hA6;
    cyc = 0;
    for (int i = 0; i < 24; i++) begin
      step(1'b1, x[slot], slot == 3'd0, "loop");
      cyc++;
      if (ch_valid) pulses.push_back(cyc);
      if (ch_valid) chk("loop.const_ch", ch, 8'hA6);
    end
    chk("loop.pulses", 8'(pulses.size()), 8'd3);
    if (pulses.size() == 3) begin
      chk("loop.gap1", 8'(pulses[1] - pulses[0]), 8'd8);
      chk("loop.gap2", 8'(pulses[2] - pulses[1]), 8'd8);
    end

    // Gaps in in_valid between slots 2/3 and 6/7.
    x = 8'h3C;
    for (int i = 0; i < 8; i++) begin
      step(1'b1, x[i], i == 0, "gap");
      if (i == 2 || i == 6) begin
        step(1'b0, 1'b1, 1'b1, "gap.idle");
        step(1'b0, 1'b0, 1'b0, "gap.idle");
      end
    end
    chk("gap.const_ch", ch, 8'h3C);
    chk("gap.const_valid", {7'b0, ch_valid}, 8'h01);

    // Marker at slot 5: resync, partial frame dropped.
    ch_before = ch;
    for (int i = 0; i < 5; i++) step(1'b1, 1'b1, i == 0, "rs.part");
    chk("rs.slot5", {5'b0, slot}, 8'h05);
    x = 8'hF0;
    for (int i = 0; i < 8; i++) begin
      step(1'b1, x[i], i == 0, "rs.f0");
      if (i == 0) begin
        chk("rs.const_err", {7'b0, sync_err}, 8'h01);
        chk("rs.ch_kept", ch, ch_before);
      end
    end
    chk("rs.const_ch", ch, 8'hF0);

    // Random traffic with occasional markers.
    for (int i = 0; i < 400; i++) begin
      step(($urandom_range(0, 3) != 0), 1'($urandom), ($urandom_range(0, 12) == 0), "rand");
    end

    // Async reset with slot at 4, then confirm HUNT behaviour.
    for (int i = 0; i < 4; i++) step(1'b1, 1'($urandom), i == 0, "s4");
    chk("s4.slot4", {5'b0, slot}, 8'h04);
    async_reset("s4.rst");
    step(1'b1, 1'b1, 1'b0, "s4.hunt");
    send_frame(8'h5A, 1'b1, "s4.f5a");
    chk("s4.const_ch", ch, 8'h5A);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
